// File: rtl/ibex_instr_mem_responder_pkg.sv
// Shared types for the instruction-side memory responder.
package ibex_instr_mem_responder_pkg;

    // One fetch response as seen by the core: data word plus access-fault flag.
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } instr_rsp_t;

    localparam int unsigned INSTR_RSP_W = 33;

    // Build a response; faulting accesses never expose SRAM data.
    function automatic instr_rsp_t make_rsp(input logic [31:0] rdata, input logic err);
        instr_rsp_t rsp;
        rsp.rdata = err ? 32'h0000_0000 : rdata;
        rsp.err   = err;
        return rsp;
    endfunction

endpackage

// File: rtl/ibex_instr_mem_responder_chk.sv
// Protocol invariants of the responder, kept apart from the datapath.
module ibex_instr_mem_responder_chk #(
    parameter int unsigned CW = 2
) (
    input logic          clk_i,
    input logic          rst_ni,
    input logic          fifo_push_i,
    input logic          fifo_pop_i,
    input logic          fifo_full_i,
    input logic          fifo_empty_i,
    input logic          rvalid_i,
    input logic          gnt_i,
    input logic          mem_req_i,
    input logic [CW-1:0] cnt_i
);

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(fifo_push_i && fifo_full_i));

    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(fifo_pop_i && fifo_empty_i));

    a_rvalid_has_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rvalid_i |-> (cnt_i != {CW{1'b0}}));

    a_mem_req_granted: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_req_i |-> gnt_i);

endmodule

// File: rtl/ibex_instr_mem_responder_fifo.sv
// Small circular response queue; holds responses the core could not take yet.
module ibex_instr_rsp_fifo
    import ibex_instr_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  instr_rsp_t push_data_i,
    input  logic       pop_i,
    output instr_rsp_t head_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    instr_rsp_t    mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Pointer advance that wraps at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PW'(DEPTH - 1)) begin
            n = {PW{1'b0}};
        end else begin
            n = p + 1'b1;
        end
        return n;
    endfunction

    // Next pointers and occupancy from this cycle's push/pop.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_i) begin
            wptr_d = ptr_inc(wptr_q);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_i) begin
            rptr_d = ptr_inc(rptr_q);
        end else begin
            rptr_d = rptr_q;
        end
        cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end

    // Pointer and occupancy registers with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= {PW{1'b0}};
            rptr_q <= {PW{1'b0}};
            cnt_q  <= {CW{1'b0}};
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/ibex_instr_mem_responder.sv
// Instruction-fetch slave in front of a 1-cycle SRAM: grant, decode, in-order responses.
module ibex_instr_mem_responder
    import ibex_instr_mem_responder_pkg::*;
#(
    parameter int unsigned NUM_OUTSTANDING = 2,
    parameter int unsigned MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned RESP_DELAY      = 0,
    localparam int unsigned AW             = $clog2(MEM_WORDS)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          instr_req_i,
    output logic          instr_gnt_o,
    input  logic [31:0]   instr_addr_i,
    output logic          instr_rvalid_o,
    output logic [31:0]   instr_rdata_o,
    output logic          instr_err_o,
    input  logic          stall_i,
    input  logic          resp_hold_i,
    output logic          mem_req_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic [31:0]   mem_rdata_i
);

    localparam int unsigned CW     = $clog2(NUM_OUTSTANDING + 1);
    // Window bounds carry a 33rd bit so a window ending at 2^32 does not wrap.
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'(MEM_WORDS) << 2);

    logic [32:0]   addr_ext_s;
    logic          in_range_s;
    logic          gnt_s;
    logic          a_valid_q, a_valid_d;
    logic          a_err_q, a_err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    instr_rsp_t    rsp_n1_s;
    logic          pipe_valid_s;
    instr_rsp_t    pipe_rsp_s;
    logic          cand_valid_s;
    instr_rsp_t    cand_rsp_s;
    instr_rsp_t    out_rsp_s;
    logic          rvalid_s;
    logic          fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
    instr_rsp_t    fifo_head_s;

    assign addr_ext_s = {1'b0, instr_addr_i};
    assign in_range_s = (addr_ext_s >= WIN_LO) && (addr_ext_s < WIN_HI);
    // No credit from a same-cycle response: the limit looks only at cnt_q.
    assign gnt_s      = instr_req_i & ~stall_i & (cnt_q < CW'(NUM_OUTSTANDING));

    assign instr_gnt_o = gnt_s;
    assign mem_req_o   = gnt_s & in_range_s;
    // BASE_ADDR is word aligned, so the word offset needs only the word-index bits.
    assign mem_addr_o  = instr_addr_i[AW+1:2] - BASE_ADDR[AW+1:2];

    // Stage A captures the grant and whether it will fault.
    always_comb begin
        a_valid_d = gnt_s;
        a_err_d   = gnt_s & ~in_range_s;
    end

    // SRAM data arrives the cycle after stage A; merge it with the fault flag.
    assign rsp_n1_s = make_rsp(mem_rdata_i, a_err_q);

    generate
        if (RESP_DELAY == 0) begin : g_no_delay
            assign pipe_valid_s = a_valid_q;
            assign pipe_rsp_s   = rsp_n1_s;
        end else begin : g_delay
            logic [RESP_DELAY-1:0] dly_valid_q, dly_valid_d;
            instr_rsp_t            dly_rsp_q [RESP_DELAY];
            instr_rsp_t            dly_rsp_d [RESP_DELAY];

            // Shift the response one stage per cycle.
            always_comb begin
                dly_valid_d[0] = a_valid_q;
                dly_rsp_d[0]   = rsp_n1_s;
                for (int i = 1; i < int'(RESP_DELAY); i++) begin
                    dly_valid_d[i] = dly_valid_q[i-1];
                    dly_rsp_d[i]   = dly_rsp_q[i-1];
                end
            end

            // Stage valid bits clear on reset.
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    dly_valid_q <= {RESP_DELAY{1'b0}};
                end else begin
                    dly_valid_q <= dly_valid_d;
                end
            end

            // Stage payloads need no reset; they are qualified by the valid bits.
            always_ff @(posedge clk_i) begin
                dly_rsp_q <= dly_rsp_d;
            end

            assign pipe_valid_s = dly_valid_q[RESP_DELAY-1];
            assign pipe_rsp_s   = dly_rsp_q[RESP_DELAY-1];
        end
    endgenerate

    // Queued responses are older than the pipeline output, so they go first.
    always_comb begin
        cand_valid_s = pipe_valid_s;
        cand_rsp_s   = pipe_rsp_s;
        if (!fifo_empty_s) begin
            cand_valid_s = 1'b1;
            cand_rsp_s   = fifo_head_s;
        end else begin
            cand_valid_s = pipe_valid_s;
            cand_rsp_s   = pipe_rsp_s;
        end
        rvalid_s    = cand_valid_s & ~resp_hold_i;
        fifo_pop_s  = rvalid_s & ~fifo_empty_s;
        // Any pipeline output that is not the one going out right now is queued.
        fifo_push_s = pipe_valid_s & ~(rvalid_s & fifo_empty_s);
        if (rvalid_s) begin
            out_rsp_s = cand_rsp_s;
        end else begin
            out_rsp_s = make_rsp(32'h0000_0000, 1'b0);
        end
        cnt_d = cnt_q + CW'(gnt_s) - CW'(rvalid_s);
    end

    assign instr_rvalid_o = rvalid_s;
    assign instr_rdata_o  = out_rsp_s.rdata;
    assign instr_err_o    = out_rsp_s.err;

    // Stage A and the outstanding counter; reset discards in-flight requests.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            a_valid_q <= 1'b0;
            a_err_q   <= 1'b0;
            cnt_q     <= {CW{1'b0}};
        end else begin
            a_valid_q <= a_valid_d;
            a_err_q   <= a_err_d;
            cnt_q     <= cnt_d;
        end
    end

    ibex_instr_rsp_fifo #(
        .DEPTH (NUM_OUTSTANDING)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (fifo_push_s),
        .push_data_i (pipe_rsp_s),
        .pop_i       (fifo_pop_s),
        .head_o      (fifo_head_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    ibex_instr_mem_responder_chk #(
        .CW (CW)
    ) u_chk (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .fifo_push_i  (fifo_push_s),
        .fifo_pop_i   (fifo_pop_s),
        .fifo_full_i  (fifo_full_s),
        .fifo_empty_i (fifo_empty_s),
        .rvalid_i     (rvalid_s),
        .gnt_i        (gnt_s),
        .mem_req_i    (mem_req_o),
        .cnt_i        (cnt_q)
    );

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Bench: two responder configurations driven by shared stimulus, each checked
// against a queue-based reference of outstanding fetches.
module tb_ibex_instr_mem_responder;

    localparam int MW0 = 1024;
    localparam int MW1 = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, stall, hold;
    logic [31:0] addr;

    logic        gnt0, rv0, err0, mreq0;
    logic [31:0] rd0, srd0;
    logic [9:0]  ma0;
    logic        gnt1, rv1, err1, mreq1;
    logic [31:0] rd1, srd1;
    logic [7:0]  ma1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference configuration per DUT: outstanding limit, base, delay, words.
    int     p_n   [2] = '{2, 3};
    longint p_base[2] = '{64'h0, 64'h0010_0000};
    int     p_dly [2] = '{0, 3};
    longint p_mw  [2] = '{MW0, MW1};

    // Reference queue of granted-but-unanswered fetches.
    int          mq_ready[2][8];
    logic        mq_err  [2][8];
    logic [31:0] mq_data [2][8];
    int          mq_head [2];
    int          mq_cnt  [2];

    always #5 clk = ~clk;

    ibex_instr_mem_responder #(
        .NUM_OUTSTANDING (2), .MEM_WORDS (MW0),
        .BASE_ADDR (32'h0000_0000), .RESP_DELAY (0)
    ) dut0 (
        .clk_i (clk), .rst_ni (rst_n),
        .instr_req_i (req), .instr_gnt_o (gnt0), .instr_addr_i (addr),
        .instr_rvalid_o (rv0), .instr_rdata_o (rd0), .instr_err_o (err0),
        .stall_i (stall), .resp_hold_i (hold),
        .mem_req_o (mreq0), .mem_addr_o (ma0), .mem_rdata_i (srd0)
    );

    ibex_instr_mem_responder #(
        .NUM_OUTSTANDING (3), .MEM_WORDS (MW1),
        .BASE_ADDR (32'h0010_0000), .RESP_DELAY (3)
    ) dut1 (
        .clk_i (clk), .rst_ni (rst_n),
        .instr_req_i (req), .instr_gnt_o (gnt1), .instr_addr_i (addr),
        .instr_rvalid_o (rv1), .instr_rdata_o (rd1), .instr_err_o (err1),
        .stall_i (stall), .resp_hold_i (hold),
        .mem_req_o (mreq1), .mem_addr_o (ma1), .mem_rdata_i (srd1)
    );

    // SRAM contents as a pure function of word index (SRAM0[0] = 32'h13).
    function automatic logic [31:0] sram_word(input int d, input logic [31:0] idx);
        return (idx * 32'h0100_0193) ^ ((d == 0) ? 32'h0000_0013 : 32'h5A5A_0013);
    endfunction

    // 1-cycle SRAMs; return junk when not strobed so stray reads show up.
    always @(posedge clk) begin
        srd0 <= mreq0 ? sram_word(0, 32'(ma0)) : (32'hBAD0_0000 ^ 32'(cyc));
        srd1 <= mreq1 ? sram_word(1, 32'(ma1)) : (32'hBAD1_0000 ^ 32'(cyc));
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Compare one DUT against the reference for this cycle, then advance it.
    task automatic model_step(input int d, input logic o_gnt, input logic o_mreq,
                              input logic [31:0] o_maddr, input logic o_rv,
                              input logic [31:0] o_rd, input logic o_err);
        longint a   = {32'h0, addr};
        bit     inr = (a >= p_base[d]) && (a < p_base[d] + 4 * p_mw[d]);
        bit     eg  = (req === 1'b1) && (stall === 1'b0) && (mq_cnt[d] < p_n[d]);
        bit     erv = (hold === 1'b0) && (mq_cnt[d] > 0) && (mq_ready[d][mq_head[d]] <= cyc);
        logic [31:0] widx = 32'((a - p_base[d]) >> 2);
        check_eq($sformatf("d%0d gnt", d), 32'(o_gnt), 32'(eg));
        check_eq($sformatf("d%0d mem_req", d), 32'(o_mreq), 32'(eg && inr));
        if (eg && inr) check_eq($sformatf("d%0d mem_addr", d), o_maddr, widx);
        check_eq($sformatf("d%0d rvalid", d), 32'(o_rv), 32'(erv));
        if (erv) begin
            check_eq($sformatf("d%0d rdata", d), o_rd, mq_data[d][mq_head[d]]);
            check_eq($sformatf("d%0d err", d), 32'(o_err), 32'(mq_err[d][mq_head[d]]));
            mq_head[d] = (mq_head[d] + 1) % 8;
            mq_cnt[d]--;
        end
        if (eg) begin
            int t = (mq_head[d] + mq_cnt[d]) % 8;
            mq_ready[d][t] = cyc + 1 + p_dly[d];
            mq_err[d][t]   = !inr;
            mq_data[d][t]  = inr ? sram_word(d, widx) : 32'h0000_0000;
            mq_cnt[d]++;
        end
    endtask

    // One clock cycle: drive, check at the falling edge, move past the next rising edge.
    task automatic step(input logic r, input logic [31:0] a, input logic s, input logic h);
        req = r; addr = a; stall = s; hold = h;
        @(negedge clk);
        model_step(0, gnt0, mreq0, 32'(ma0), rv0, rd0, err0);
        model_step(1, gnt1, mreq1, 32'(ma1), rv1, rd1, err1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // Synchronous reset for one edge, then confirm every response output is quiet.
    task automatic do_reset();
        rst_n = 1'b0; req = 1'b0; stall = 1'b0; hold = 1'b0; addr = 32'h0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            mq_head[d] = 0;
            mq_cnt[d]  = 0;
        end
        @(negedge clk);
        check_eq("rst d0 gnt", 32'(gnt0), 32'h0);
        check_eq("rst d0 rvalid", 32'(rv0), 32'h0);
        check_eq("rst d0 rdata", rd0, 32'h0);
        check_eq("rst d0 err", 32'(err0), 32'h0);
        check_eq("rst d0 mem_req", 32'(mreq0), 32'h0);
        check_eq("rst d1 rvalid", 32'(rv1), 32'h0);
        check_eq("rst d1 rdata", rd1, 32'h0);
        check_eq("rst d1 mem_req", 32'(mreq1), 32'h0);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 7))
            0, 1, 2: a = 32'($urandom_range(0, MW0 - 1)) << 2;
            3, 4:    a = 32'h0010_0000 + (32'($urandom_range(0, MW1 - 1)) << 2);
            5:       a = ($urandom_range(0, 1) == 0) ? 32'h0000_1000 : 32'h0010_0400;
            6:       a = $urandom;
            default: a = 32'hFFFF_FFFC;
        endcase
        return a | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        int hold_left = 0;
        rst_n = 1'b0; req = 1'b0; stall = 1'b0; hold = 1'b0; addr = 32'h0;
        do_reset();

        // Single fetch of word 0.
        step(1'b1, 32'h0, 1'b0, 1'b0);
        idle(5);
        // Back-to-back fetches with request held.
        step(1'b1, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h4, 1'b0, 1'b0);
        step(1'b1, 32'h8, 1'b0, 1'b0);
        idle(6);
        // Hold responses while requesting; counter saturates, then drains.
        for (int i = 0; i < 5; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h20, 1'b0, 1'b0);
        idle(6);
        // Window edges, wrap-around and both ends of each SRAM.
        step(1'b1, 32'h0000_1000, 1'b0, 1'b0); idle(4);
        step(1'b1, 32'h0010_0400, 1'b0, 1'b0); idle(4);
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0); idle(4);
        step(1'b1, 32'h0000_0FFC, 1'b0, 1'b0); idle(4);
        step(1'b1, 32'h0010_03FC, 1'b0, 1'b0); idle(4);
        step(1'b1, 32'h0010_0000, 1'b0, 1'b0); idle(4);
        step(1'b1, 32'h000F_FFFC, 1'b0, 1'b0); idle(4);
        // Stall suppresses grants.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h0, 1'b1, 1'b0);
        // Reset with fetches in flight, then a fresh fetch.
        step(1'b1, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h0010_0004, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 32'h10, 1'b0, 1'b0);
        step(1'b1, 32'h0010_0010, 1'b0, 1'b0);
        idle(6);

        // Random traffic with bursts of hold, stall and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            logic h;
            if (hold_left > 0) begin
                h = 1'b1;
                hold_left--;
            end else if ($urandom_range(0, 19) == 0) begin
                hold_left = $urandom_range(1, 8);
                h = 1'b1;
            end else begin
                h = 1'b0;
            end
            if ($urandom_range(0, 499) == 0) do_reset();
            step(($urandom_range(0, 3) != 0), rand_addr(), ($urandom_range(0, 7) == 0), h);
        end
        idle(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
